// File: rtl/acc_ctrl.sv
// acc_ctrl: sequencer that fetches 9-bit {op,imm} words over the imem handshake.
// It moves operands to and from dmem, drives the external accumulator alu, owns
// acc_q and the z/n flags, and resolves jumps and branches.
// Optional feature: define ACC_CTRL_PERF_EN to add the cyc_cnt/ins_cnt
// performance counter ports. When it is undefined, the ports and logic are absent.
module acc_ctrl #(
    parameter int PC_W     = 8,
    parameter int PROG_LEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            done,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [8:0]      imem_rdata,
    input  logic            imem_valid,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [4:0]      dmem_addr,
    output logic [7:0]      dmem_wdata,
    input  logic [7:0]      dmem_rdata,
    input  logic            dmem_ack,
    output logic [3:0]      alu_op,
    output logic [7:0]      alu_in_a,
    output logic [7:0]      alu_in_acc,
    input  logic [7:0]      alu_acc,
    input  logic            alu_z,
    input  logic            alu_neg,
    output logic [7:0]      acc_q,
    output logic [PC_W-1:0] pc
`ifdef ACC_CTRL_PERF_EN
    ,
    output logic [15:0]     cyc_cnt,
    output logic [15:0]     ins_cnt
`endif
);

    localparam logic [3:0] kNOP = 4'd0,  kLDI = 4'd1,  kADD = 4'd2,  kSUB = 4'd3;
    localparam logic [3:0] kAND = 4'd4,  kXOR = 4'd5,  kMLD = 4'd6,  kLDR = 4'd7;
    localparam logic [3:0] kMST = 4'd8,  kSTR = 4'd9,  kJMP = 4'd10, kBRZ = 4'd11;
    localparam logic [3:0] kBRN = 4'd12, kCLR = 4'd13, kOR  = 4'd14, kNOT = 4'd15;

    localparam logic [PC_W-1:0] PROG_END = PC_W'(PROG_LEN);

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, MEM, EXEC, HALT} state_t;

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [7:0]      r_acc;
    logic [8:0]      r_ir;
    logic            r_z;
    logic            r_n;
    logic            r_done;
    logic            r_imemReq;
    logic            r_dmemReq;
    logic            r_dmemWe;
    logic [3:0]      r_aluOp;
    logic [7:0]      r_aluInA;

    logic [3:0]      w_op;
    logic [4:0]      w_imm;
    logic            w_isMemRd;
    logic            w_isMemWr;
    logic [PC_W-1:0] w_pcInc;
    logic [PC_W-1:0] w_pcBr;
    logic [PC_W-1:0] w_pcExec;

    assign w_op    = r_ir[8:5];
    assign w_imm   = r_ir[4:0];
    assign w_pcInc = r_pc + PC_W'(1);
    assign w_pcBr  = r_pc + {{(PC_W-5){w_imm[4]}}, w_imm};

    assign done       = r_done;
    assign imem_req   = r_imemReq;
    assign imem_addr  = r_pc;
    assign dmem_req   = r_dmemReq;
    assign dmem_we    = r_dmemWe;
    assign dmem_addr  = w_imm;
    assign dmem_wdata = r_acc;
    assign alu_op     = r_aluOp;
    assign alu_in_a   = r_aluInA;
    assign alu_in_acc = r_acc;
    assign acc_q      = r_acc;
    assign pc         = r_pc;

    // Classify the latched instruction by its dmem traffic
    always_comb begin
        w_isMemRd = 1'b0;
        w_isMemWr = 1'b0;
        case (w_op)
            kADD, kSUB, kAND, kXOR, kMLD, kLDR: w_isMemRd = 1'b1;
            kMST, kSTR:                         w_isMemWr = 1'b1;
            default:                            ;
        endcase
    end

    // Next pc once the EXEC cycle retires: jump, taken branch or plain increment
    always_comb begin
        w_pcExec = w_pcInc;
        case (w_op)
            kJMP:    w_pcExec = {{(PC_W-5){1'b0}}, w_imm};
            kBRZ:    if (r_z) w_pcExec = w_pcBr;
            kBRN:    if (r_n) w_pcExec = w_pcBr;
            default: ;
        endcase
    end

    // Main sequencer; every output is a register, and imem_req is precomputed from the pc being loaded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_pc      <= '0;
            r_acc     <= '0;
            r_ir      <= '0;
            r_z       <= 1'b0;
            r_n       <= 1'b0;
            r_done    <= 1'b0;
            r_imemReq <= 1'b0;
            r_dmemReq <= 1'b0;
            r_dmemWe  <= 1'b0;
            r_aluOp   <= '0;
            r_aluInA  <= '0;
        end else begin
            case (r_state)
                IDLE, HALT: begin
                    if (start) begin
                        r_state   <= FETCH;
                        r_pc      <= '0;
                        r_done    <= 1'b0;
                        r_imemReq <= (PROG_END != '0);
                    end
                end
                FETCH: begin
                    if (r_pc == PROG_END) begin
                        r_state   <= HALT;
                        r_done    <= 1'b1;
                        r_imemReq <= 1'b0;
                    end else if (imem_valid) begin
                        r_ir      <= imem_rdata;
                        r_imemReq <= 1'b0;
                        r_state   <= DECODE;
                    end
                end
                DECODE: begin
                    if (w_isMemRd || w_isMemWr) begin
                        r_state   <= MEM;
                        r_dmemReq <= 1'b1;
                        r_dmemWe  <= w_isMemWr;
                    end else begin
                        r_state  <= EXEC;
                        r_aluOp  <= w_op;
                        r_aluInA <= {3'b000, w_imm};
                    end
                end
                MEM: begin
                    if (dmem_ack) begin
                        r_dmemReq <= 1'b0;
                        r_dmemWe  <= 1'b0;
                        if (r_dmemWe) begin
                            r_pc      <= w_pcInc;
                            r_imemReq <= (w_pcInc != PROG_END);
                            r_state   <= FETCH;
                        end else begin
                            r_aluOp  <= w_op;
                            r_aluInA <= dmem_rdata;
                            r_state  <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    r_aluOp   <= '0;
                    r_aluInA  <= '0;
                    r_pc      <= w_pcExec;
                    r_imemReq <= (w_pcExec != PROG_END);
                    r_state   <= FETCH;
                    case (w_op)
                        kCLR: begin
                            r_z <= 1'b0;
                            r_n <= 1'b0;
                        end
                        kJMP, kBRZ, kBRN, kMST, kSTR: ;
                        default: begin
                            r_acc <= alu_acc;
                            r_z   <= alu_z;
                            r_n   <= alu_neg;
                        end
                    endcase
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef ACC_CTRL_PERF_EN
    logic [15:0] r_cycCnt;
    logic [15:0] r_insCnt;
    logic        w_startAcc;
    logic        w_busy;
    logic        w_retire;

    assign w_startAcc = start && ((r_state == IDLE) || (r_state == HALT));
    assign w_busy     = (r_state != IDLE) && (r_state != HALT);
    assign w_retire   = (r_state == EXEC) || ((r_state == MEM) && dmem_ack && r_dmemWe);
    assign cyc_cnt    = r_cycCnt;
    assign ins_cnt    = r_insCnt;

    // Saturating busy-cycle and retired-instruction counters, cleared by each accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycCnt <= '0;
            r_insCnt <= '0;
        end else if (w_startAcc) begin
            r_cycCnt <= '0;
            r_insCnt <= '0;
        end else begin
            if (w_busy && (r_cycCnt != 16'hFFFF))
                r_cycCnt <= r_cycCnt + 16'd1;
            if (w_retire && (r_insCnt != 16'hFFFF))
                r_insCnt <= r_insCnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_acc_ctrl.sv
// tb_acc_ctrl: directed bench for acc_ctrl with imem/dmem responders and an alu model.
module tb_acc_ctrl;

    localparam logic [3:0] kNOP = 4'd0,  kLDI = 4'd1,  kADD = 4'd2,  kSUB = 4'd3;
    localparam logic [3:0] kAND = 4'd4,  kXOR = 4'd5,  kMLD = 4'd6,  kLDR = 4'd7;
    localparam logic [3:0] kMST = 4'd8,  kSTR = 4'd9,  kJMP = 4'd10, kBRZ = 4'd11;
    localparam logic [3:0] kBRN = 4'd12, kCLR = 4'd13, kOR  = 4'd14, kNOT = 4'd15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       done;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic [8:0] imem_rdata = '0;
    logic       imem_valid = 1'b0;
    logic       dmem_req;
    logic       dmem_we;
    logic [4:0] dmem_addr;
    logic [7:0] dmem_wdata;
    logic [7:0] dmem_rdata = '0;
    logic       dmem_ack = 1'b0;
    logic [3:0] alu_op;
    logic [7:0] alu_in_a;
    logic [7:0] alu_in_acc;
    logic [7:0] alu_acc;
    logic       alu_z;
    logic       alu_neg;
    logic [7:0] acc_q;
    logic [7:0] pc;

    logic [8:0] prog [0:255];
    logic [7:0] dmem [0:31];
    int imemDelay = 0;
    int dmemDelay = 0;
    int imemWait = 0;
    int dmemWait = 0;
    int checkCount = 0;
    int errorCount = 0;

    acc_ctrl #(.PC_W(8), .PROG_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .done(done),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_valid(imem_valid),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .alu_op(alu_op), .alu_in_a(alu_in_a), .alu_in_acc(alu_in_acc),
        .alu_acc(alu_acc), .alu_z(alu_z), .alu_neg(alu_neg),
        .acc_q(acc_q), .pc(pc)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    // Reference alu behaviour for each opcode
    always @* begin
        case (alu_op)
            kLDI, kMLD, kLDR: alu_acc = alu_in_a;
            kADD:             alu_acc = alu_in_acc + alu_in_a;
            kSUB:             alu_acc = alu_in_acc - alu_in_a;
            kAND:             alu_acc = alu_in_acc & alu_in_a;
            kXOR:             alu_acc = alu_in_acc ^ alu_in_a;
            kOR:              alu_acc = alu_in_acc | alu_in_a;
            kNOT:             alu_acc = ~alu_in_acc;
            default:          alu_acc = alu_in_acc;
        endcase
        alu_z   = (alu_acc == 8'h00);
        alu_neg = alu_acc[7];
    end

    // Instruction memory responder with a programmable wait count
    always @(negedge clk) begin
        if (imem_req && !imem_valid) begin
            if (imemWait >= imemDelay) begin
                imem_valid = 1'b1;
                imem_rdata = prog[imem_addr];
                imemWait = 0;
            end else begin
                imemWait++;
            end
        end else begin
            imem_valid = 1'b0;
            imemWait = 0;
        end
    end

    // Data memory responder with a programmable wait count; writes land when acked
    always @(negedge clk) begin
        if (dmem_req && !dmem_ack) begin
            if (dmemWait >= dmemDelay) begin
                dmem_ack = 1'b1;
                dmem_rdata = dmem[dmem_addr];
                if (dmem_we) dmem[dmem_addr] = dmem_wdata;
                dmemWait = 0;
            end else begin
                dmemWait++;
            end
        end else begin
            dmem_ack = 1'b0;
            dmemWait = 0;
        end
    end

    // Watchdog so a stuck design still ends the run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errorCount);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [8:0] ins(input logic [3:0] op, input logic [4:0] imm);
        return {op, imm};
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold reset for a cycle, clear both memories and restore zero-wait responders
    task automatic applyReset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        imemDelay = 0;
        dmemDelay = 0;
        for (int i = 0; i < 256; i++) prog[i] = ins(kNOP, 5'd0);
        for (int i = 0; i < 32; i++) dmem[i] = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One-cycle start pulse; returns on the negedge where the design sits in FETCH at pc 0
    task automatic applyStimulus();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        // Reset state
        applyReset();
        checkOutput("rst_pc", 16'(pc), 16'h0);
        checkOutput("rst_acc", 16'(acc_q), 16'h0);
        checkOutput("rst_done", 16'(done), 16'h0);
        checkOutput("rst_imem_req", 16'(imem_req), 16'h0);
        checkOutput("rst_dmem_req", 16'(dmem_req), 16'h0);
        checkOutput("rst_alu_op", 16'(alu_op), 16'h0);

        // LDI 5: three cycles from fetch to retire
        prog[0] = ins(kLDI, 5'd5);
        applyStimulus();
        checkOutput("ldi_imem_req", 16'(imem_req), 16'h1);
        checkOutput("ldi_imem_addr", 16'(imem_addr), 16'h0);
        waitCycles(1);
        checkOutput("ldi_decode_alu_op", 16'(alu_op), 16'h0);
        waitCycles(1);
        checkOutput("ldi_exec_alu_op", 16'(alu_op), 16'(kLDI));
        checkOutput("ldi_exec_in_a", 16'(alu_in_a), 16'h5);
        checkOutput("ldi_exec_pc", 16'(pc), 16'h0);
        waitCycles(1);
        checkOutput("ldi_pc", 16'(pc), 16'h1);
        checkOutput("ldi_acc", 16'(acc_q), 16'h05);

        // LDI 5, ADD [3] with mem[3]=2
        applyReset();
        prog[0] = ins(kLDI, 5'd5);
        prog[1] = ins(kADD, 5'd3);
        dmem[3] = 8'h02;
        applyStimulus();
        waitCycles(5);
        checkOutput("add_dmem_req", 16'(dmem_req), 16'h1);
        checkOutput("add_dmem_addr", 16'(dmem_addr), 16'h3);
        checkOutput("add_dmem_we", 16'(dmem_we), 16'h0);
        waitCycles(1);
        checkOutput("add_alu_op", 16'(alu_op), 16'(kADD));
        checkOutput("add_in_a", 16'(alu_in_a), 16'h02);
        waitCycles(1);
        checkOutput("add_acc", 16'(acc_q), 16'h07);
        checkOutput("add_pc", 16'(pc), 16'h2);

        // LDI 2, SUB [7]=2 sets z, BRZ -2 at pc 2 goes back to 0
        applyReset();
        prog[0] = ins(kLDI, 5'd2);
        prog[1] = ins(kSUB, 5'd7);
        prog[2] = ins(kBRZ, 5'h1E);
        dmem[7] = 8'h02;
        applyStimulus();
        waitCycles(9);
        checkOutput("brz_t_pre_pc", 16'(pc), 16'h2);
        checkOutput("brz_t_acc", 16'(acc_q), 16'h00);
        waitCycles(1);
        checkOutput("brz_taken_pc", 16'(pc), 16'h0);

        // Same program with mem[7]=1: z clear, branch falls through to pc 3
        applyReset();
        prog[0] = ins(kLDI, 5'd2);
        prog[1] = ins(kSUB, 5'd7);
        prog[2] = ins(kBRZ, 5'h1E);
        dmem[7] = 8'h01;
        applyStimulus();
        waitCycles(10);
        checkOutput("brz_nt_pc", 16'(pc), 16'h3);
        checkOutput("brz_nt_acc", 16'(acc_q), 16'h01);

        // MST 4 with a 3-cycle ack delay: request held stable for 4 cycles
        applyReset();
        prog[0] = ins(kLDI, 5'd9);
        prog[1] = ins(kMST, 5'd4);
        dmemDelay = 3;
        applyStimulus();
        waitCycles(5);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("mst_req_%0d", i), 16'(dmem_req), 16'h1);
            checkOutput($sformatf("mst_addr_%0d", i), 16'(dmem_addr), 16'h4);
            checkOutput($sformatf("mst_we_%0d", i), 16'(dmem_we), 16'h1);
            checkOutput($sformatf("mst_wdata_%0d", i), 16'(dmem_wdata), 16'h09);
            waitCycles(1);
        end
        checkOutput("mst_req_done", 16'(dmem_req), 16'h0);
        checkOutput("mst_pc", 16'(pc), 16'h2);
        checkOutput("mst_mem4", 16'(dmem[4]), 16'h09);
        checkOutput("mst_acc", 16'(acc_q), 16'h09);

        // Four LDIs reach pc==PROG_LEN, halt, then restart keeping acc
        applyReset();
        for (int i = 0; i < 4; i++) prog[i] = ins(kLDI, 5'(i + 1));
        applyStimulus();
        waitCycles(12);
        checkOutput("halt_pc", 16'(pc), 16'h4);
        checkOutput("halt_no_imem_req", 16'(imem_req), 16'h0);
        checkOutput("halt_done_early", 16'(done), 16'h0);
        waitCycles(1);
        checkOutput("halt_done", 16'(done), 16'h1);
        checkOutput("halt_acc", 16'(acc_q), 16'h04);
        applyStimulus();
        checkOutput("restart_done", 16'(done), 16'h0);
        checkOutput("restart_pc", 16'(pc), 16'h0);
        checkOutput("restart_acc", 16'(acc_q), 16'h04);

        // LDI 1, SUB [2]=2 gives FF and sets n, BRN +2 at pc 2 lands on pc 4 and halts
        applyReset();
        prog[0] = ins(kLDI, 5'd1);
        prog[1] = ins(kSUB, 5'd2);
        prog[2] = ins(kBRN, 5'd2);
        dmem[2] = 8'h02;
        applyStimulus();
        waitCycles(10);
        checkOutput("brn_pc", 16'(pc), 16'h4);
        checkOutput("brn_acc", 16'(acc_q), 16'hFF);
        waitCycles(1);
        checkOutput("brn_done", 16'(done), 16'h1);

        // JMP 3 with a 2-cycle imem wait
        applyReset();
        prog[0] = ins(kJMP, 5'd3);
        imemDelay = 2;
        applyStimulus();
        waitCycles(4);
        checkOutput("jmp_pre_pc", 16'(pc), 16'h0);
        waitCycles(1);
        checkOutput("jmp_pc", 16'(pc), 16'h3);
        checkOutput("jmp_acc", 16'(acc_q), 16'h00);

        // Reset asserted in the middle of a stalled read
        applyReset();
        prog[0] = ins(kLDI, 5'd3);
        prog[1] = ins(kMLD, 5'd5);
        dmemDelay = 10;
        applyStimulus();
        waitCycles(5);
        checkOutput("mrst_req_before", 16'(dmem_req), 16'h1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mrst_req", 16'(dmem_req), 16'h0);
        checkOutput("mrst_pc", 16'(pc), 16'h0);
        checkOutput("mrst_acc", 16'(acc_q), 16'h00);
        checkOutput("mrst_done", 16'(done), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        waitCycles(2);
        checkOutput("mrst_idle_imem_req", 16'(imem_req), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
